pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Parametrised program-counter unit with an instruction-fetch handshake. It supersedes the plain PC register by adding:
- a configurable width, reset vector and step;
- a request/grant handshake to instruction memory;
- pending-redirect buffering while a fetch is outstanding;
- a trap vector and a stall state.

It sits at the head of the IF stage and feeds fetched-PC and valid to IF/ID.

Parameters:
- XLEN, 32: PC and address width in bits.
- RESET_VEC, 32'h0000_0000: PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100: PC value loaded on a trap.
- STEP, 4: sequential increment in bytes.

Ports:
- clk  in  1  Clock. Single clock domain; all state updates on the posedge of clk.
- rst  in  1  Reset. Asynchronous, active-high.
- stall  in  1  Hold fetch after the current grant.
- redirect_valid  in  1  Branch/jump taken.
- redirect_pc  in  XLEN  Branch/jump target.
- trap_valid  in  1  Exception/interrupt taken.
- if_req  out  1  Fetch request to imem.
- if_addr  out  XLEN  Fetch address (equals pc_out).
- if_gnt  in  1  Imem accepted the request this cycle.
- fetch_valid  out  1  One-cycle pulse: a correct-path fetch was granted.
- fetch_pc  out  XLEN  PC of the granted fetch.
- pc_out  out  XLEN  Current PC.
- pc_plus_step  out  XLEN  pc_out + STEP, combinational.
- misalign  out  1  One-cycle pulse on a misaligned redirect (optional feature; tied 0 when the feature is compiled out).

Behaviour:
Reset values (async on rst):
- state = S_BOOT, pc_out = RESET_VEC, if_req = 0.
- fetch_valid = 0, fetch_pc = 0, pend_valid = 0, pend_pc = 0, misalign = 0.

States:
- S_BOOT: if_req = 0. Go to S_REQ next cycle unconditionally. A redirect or trap taken here updates pc_out.
- S_REQ: if_req = 1, if_addr = pc_out.
  - Both stay stable until if_gnt; pc_out does not change while if_req = 1 and if_gnt = 0.
  - On if_gnt: fetch_pc <= pc_out, then pc_out <= next PC (priority rules below).
  - If stall = 1 in the grant cycle, go to S_STALL; otherwise stay in S_REQ (back-to-back fetch).
- S_STALL: if_req = 0. Redirect or trap updates pc_out directly. Go to S_REQ when stall = 0.

Next-PC priority, highest first:
1. trap_valid → TRAP_VEC.
2. redirect_valid → redirect_pc.
3. pend_valid → pend_pc.
4. Otherwise → pc_out + STEP.

Adder wraps modulo 2^XLEN, no overflow flag.

Pending buffer (S_REQ with if_gnt = 0):
- A trap or redirect cannot move the PC, so it is latched: pend_valid <= 1, pend_pc <= target.
- Trap overwrites redirect. A later redirect overwrites an earlier redirect, but never a pending trap.
- Cleared on the grant that consumes it.

fetch_valid:
- Asserted one cycle after a grant, together with a registered fetch_pc.
- Suppressed (0) if pend_valid was set, or trap_valid/redirect_valid was high, in the grant cycle (wrong-path fetch).

Simultaneous events:
- Trap and redirect in the same cycle: trap wins and the redirect is dropped.
- Redirect in the same cycle as if_gnt: applied directly, not buffered.

Reset mid-request: if_req drops immediately (async) and the pending buffer is cleared.

stall only takes effect at a grant; it never withdraws an asserted if_req.

Optional Feature:
Macro: PC_MISALIGN_TRAP_EN
- Defined: a redirect with redirect_pc[1:0] != 0 is treated as a trap.
  - Target becomes TRAP_VEC under the same buffering rules.
  - misalign pulses for one cycle in the cycle after the redirect is sampled.
- Undefined: redirect_pc[1:0] is forced to 2'b00 before use, and misalign is constant 0.

Test Plan:
1. Reset then release, if_gnt tied 1 → cycle 1 if_req = 0; then if_addr = 0x0, 0x4, 0x8; fetch_valid pulses with fetch_pc = 0x0, 0x4, 0x8.
2. if_gnt held 0 for 3 cycles with redirect_valid = 1 to 0x40 in the second cycle → if_addr stays 0x0; on grant fetch_valid = 0; next if_addr = 0x40.
3. trap_valid and redirect_valid (0x80) in the same grant cycle → next if_addr = 0x100; fetch_valid = 0.
4. stall = 1 during the grant at 0x8 → if_req = 0 while stalled; redirect to 0x200 during the stall; stall released → if_addr = 0x200.
5. rst asserted while if_req = 1 and pend_valid = 1 → if_req = 0 and pc_out = RESET_VEC asynchronously; after release the first fetch is at 0x0 with no pending redirect applied.
6. Redirect to 0x42:
   - with PC_MISALIGN_TRAP_EN defined → misalign pulses and next if_addr = 0x100;
   - without it → next if_addr = 0x40 and misalign = 0.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program counter with imem request/grant handshake, redirect buffering, trap vector and stall.
// Optional PC_MISALIGN_TRAP_EN: misaligned redirect targets are turned into traps.
module pc_fetch_ctrl #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int unsigned     STEP      = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            trap_valid_i,
  output logic            if_req_o,
  output logic [XLEN-1:0] if_addr_o,
  input  logic            if_gnt_i,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] fetch_pc_o,
  output logic [XLEN-1:0] pc_out_o,
  output logic [XLEN-1:0] pc_plus_step_o,
  output logic            misalign_o
);

  typedef enum logic [1:0] {StBoot, StReq, StStall} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            pend_valid_q, pend_valid_d;
  logic            pend_trap_q, pend_trap_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            misalign_q, misalign_d;

  logic            mis_trap;
  logic            eff_trap;
  logic            eff_redir;
  logic [XLEN-1:0] redir_tgt;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] grant_pc;

`ifdef PC_MISALIGN_TRAP_EN
  assign mis_trap  = redirect_valid_i & (redirect_pc_i[1:0] != 2'b00);
  assign redir_tgt = redirect_pc_i;
`else
  assign mis_trap  = 1'b0;
  assign redir_tgt = redirect_pc_i & ~XLEN'(3);
`endif

  assign eff_trap  = trap_valid_i | mis_trap;
  assign eff_redir = redirect_valid_i & ~mis_trap;
  assign pc_inc    = pc_q + XLEN'(STEP);

  always_comb begin
    if (eff_trap)          grant_pc = TRAP_VEC;
    else if (eff_redir)    grant_pc = redir_tgt;
    else if (pend_valid_q) grant_pc = pend_pc_q;
    else                   grant_pc = pc_inc;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_valid_d = 1'b0;
    pend_valid_d  = pend_valid_q;
    pend_trap_d   = pend_trap_q;
    pend_pc_d     = pend_pc_q;
    misalign_d    = mis_trap;

    unique case (state_q)
      StBoot, StStall: begin
        if (eff_trap)       pc_d = TRAP_VEC;
        else if (eff_redir) pc_d = redir_tgt;
        if (state_q == StBoot || !stall_i) state_d = StReq;
      end
      StReq: begin
        if (if_gnt_i) begin
          fetch_pc_d    = pc_q;
          pc_d          = grant_pc;
          // Wrong-path fetch: a redirect is pending or arriving with this grant.
          fetch_valid_d = ~(pend_valid_q | trap_valid_i | redirect_valid_i);
          pend_valid_d  = 1'b0;
          pend_trap_d   = 1'b0;
          pend_pc_d     = '0;
          state_d       = stall_i ? StStall : StReq;
        end else if (eff_trap) begin
          pend_valid_d = 1'b1;
          pend_trap_d  = 1'b1;
          pend_pc_d    = TRAP_VEC;
        end else if (eff_redir && !pend_trap_q) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = redir_tgt;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StBoot;
      pc_q          <= RESET_VEC;
      fetch_pc_q    <= '0;
      fetch_valid_q <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_trap_q   <= 1'b0;
      pend_pc_q     <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_valid_q <= fetch_valid_d;
      pend_valid_q  <= pend_valid_d;
      pend_trap_q   <= pend_trap_d;
      pend_pc_q     <= pend_pc_d;
      misalign_q    <= misalign_d;
    end
  end

  assign if_req_o       = (state_q == StReq);
  assign if_addr_o      = pc_q;
  assign pc_out_o       = pc_q;
  assign pc_plus_step_o = pc_inc;
  assign fetch_valid_o  = fetch_valid_q;
  assign fetch_pc_o     = fetch_pc_q;
  assign misalign_o     = misalign_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_step;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .stall_i          (stall),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .trap_valid_i     (trap_valid),
    .if_req_o         (if_req),
    .if_addr_o        (if_addr),
    .if_gnt_i         (if_gnt),
    .fetch_valid_o    (fetch_valid),
    .fetch_pc_o       (fetch_pc),
    .pc_out_o         (pc_out),
    .pc_plus_step_o   (pc_plus_step),
    .misalign_o       (misalign)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_chk(input string tag, input logic [31:0] addr, input logic fv,
                           input logic [31:0] fpc);
    check_eq({tag, ".if_addr"}, if_addr, addr);
    check_eq({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(fv));
    if (fv) check_eq({tag, ".fetch_pc"}, fetch_pc, fpc);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    trap_valid = 1'b0; if_gnt = 1'b1;
    tick();
    check_eq("rst.if_req", 32'(if_req), 0);
    check_eq("rst.pc", pc_out, 32'h0);
    check_eq("rst.fetch_valid", 32'(fetch_valid), 0);
    check_eq("rst.fetch_pc", fetch_pc, 32'h0);
    check_eq("rst.misalign", 32'(misalign), 0);

    // 1: sequential fetch with grant tied high
    rst = 1'b0;
    check_eq("t1.boot_req", 32'(if_req), 0);
    tick();
    check_eq("t1.req", 32'(if_req), 1);
    check_eq("t1.addr0", if_addr, 32'h0);
    tick(); fetch_chk("t1.f0", 32'h4, 1'b1, 32'h0);
    tick(); fetch_chk("t1.f1", 32'h8, 1'b1, 32'h4);
    tick(); fetch_chk("t1.f2", 32'hC, 1'b1, 32'h8);
    check_eq("t1.pc_plus_step", pc_plus_step, 32'h10);

    // 2: redirect buffered while grant is withheld
    if_gnt = 1'b0;
    tick(); fetch_chk("t2.wait0", 32'hC, 1'b0, 32'h0);
    check_eq("t2.req_held", 32'(if_req), 1);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick(); fetch_chk("t2.wait1", 32'hC, 1'b0, 32'h0);
    redirect_valid = 1'b0;
    tick(); fetch_chk("t2.wait2", 32'hC, 1'b0, 32'h0);
    if_gnt = 1'b1;
    tick(); fetch_chk("t2.consume", 32'h40, 1'b0, 32'h0);
    tick(); fetch_chk("t2.after", 32'h44, 1'b1, 32'h40);

    // 3: trap and redirect together at a grant
    trap_valid = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick(); fetch_chk("t3.trap", 32'h100, 1'b0, 32'h0);
    trap_valid = 1'b0; redirect_valid = 1'b0;
    tick(); fetch_chk("t3.f0", 32'h104, 1'b1, 32'h100);
    tick(); fetch_chk("t3.f1", 32'h108, 1'b1, 32'h104);

    // 4: stall at a grant, redirect while stalled
    stall = 1'b1;
    tick(); fetch_chk("t4.stall_gnt", 32'h10C, 1'b1, 32'h108);
    check_eq("t4.req_off", 32'(if_req), 0);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick(); fetch_chk("t4.redir", 32'h200, 1'b0, 32'h0);
    check_eq("t4.req_off2", 32'(if_req), 0);
    redirect_valid = 1'b0;
    tick(); check_eq("t4.hold", if_addr, 32'h200);
    stall = 1'b0;
    tick(); check_eq("t4.req_on", 32'(if_req), 1);
    check_eq("t4.addr", if_addr, 32'h200);
    tick(); fetch_chk("t4.f0", 32'h204, 1'b1, 32'h200);
    // stall without a grant must not drop the request
    if_gnt = 1'b0; stall = 1'b1;
    tick(); check_eq("t4.req_kept", 32'(if_req), 1);
    check_eq("t4.addr_kept", if_addr, 32'h204);
    stall = 1'b0;

    // 5: async reset with a pending redirect
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("t5.req_async", 32'(if_req), 0);
    check_eq("t5.pc_async", pc_out, 32'h0);
    tick();
    rst = 1'b0; if_gnt = 1'b1;
    tick(); check_eq("t5.addr0", if_addr, 32'h0);
    tick(); fetch_chk("t5.f0", 32'h4, 1'b1, 32'h0);

    // 6: misaligned redirect at a grant
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick();
`ifdef PC_MISALIGN_TRAP_EN
    fetch_chk("t6.target", 32'h100, 1'b0, 32'h0);
    check_eq("t6.misalign", 32'(misalign), 1);
`else
    fetch_chk("t6.target", 32'h40, 1'b0, 32'h0);
    check_eq("t6.misalign", 32'(misalign), 0);
`endif
    redirect_valid = 1'b0;
    tick(); check_eq("t6.misalign_clr", 32'(misalign), 0);

    // 7: pending trap is not overwritten by a later redirect
    if_gnt = 1'b0; trap_valid = 1'b1;
    tick();
    trap_valid = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h500;
    tick();
    redirect_valid = 1'b0; if_gnt = 1'b1;
    tick(); fetch_chk("t7.trap_kept", 32'h100, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
